// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//
// Purpose:
//   Per-frame sequencer for a 2x2 ball drawer. Each frame it erases the ball
//   at its old position, steps it by one pixel (bouncing off the screen
//   edges), redraws it at the new position, then idles for WAIT_CYCLES
//   clocks before the next frame.
//
// Configuration macro:
//   BALL_ERASE_EN - when defined, the erase pass (ERASE/ERASE_REL) is built
//                   and color toggles between 3'b000 (erase) and 3'b111
//                   (draw). When undefined, no erase pass is built, the ball
//                   leaves a trail, and color is constant 3'b111.
//
// Ports:
//   clk           in   1  system clock
//   reset_n       in   1  asynchronous active-low reset
//   enable        in   1  run ball motion while high
//   drawer_start  out  1  start request to ball drawer
//   drawer_done   in   1  one-cycle done pulse from ball drawer
//   ball_x        out  9  top-left x sent to drawer
//   ball_y        out  8  top-left y sent to drawer
//   color         out  3  pixel colour: 3'b000 erase, 3'b111 draw
//   busy          out  1  high in any state other than IDLE
//   bounce        out  1  one-cycle pulse when a direction flips
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
    parameter int X_MAX       = 319,
    parameter int Y_MAX       = 239,
    parameter int X_INIT      = 160,
    parameter int Y_INIT      = 120,
    parameter int WAIT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       drawer_start,
    input  logic       drawer_done,
    output logic [8:0] ball_x,
    output logic [7:0] ball_y,
    output logic [2:0] color,
    output logic       busy,
    output logic       bounce
);

    // WAIT_CYCLES must be at least 1; the counter runs 0..WAIT_CYCLES-1.
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    localparam logic [8:0] X_LAST  = 9'(X_MAX - 1);
    localparam logic [7:0] Y_LAST  = 8'(Y_MAX - 1);
    localparam logic [8:0] X_RESET = 9'(X_INIT);
    localparam logic [7:0] Y_RESET = 8'(Y_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef BALL_ERASE_EN
        S_ERASE,
        S_ERASE_REL,
`endif
        S_MOVE,
        S_DRAW,
        S_DRAW_REL,
        S_WAIT
    } state_t;

    state_t          state;
    logic            dir_x;       // 1 = moving right (+1), 0 = moving left (-1)
    logic            dir_y;       // 1 = moving down (+1), 0 = moving up (-1)
    logic [CW-1:0]   wait_cnt;

    logic [8:0]      next_x;
    logic [7:0]      next_y;
    logic            next_dir_x;
    logic            next_dir_y;
    logic            flip_x;
    logic            flip_y;

    // Next x position and direction. Hitting an edge reverses direction and
    // steps one pixel back inward in the same move, so the ball never sits
    // outside 0..X_MAX-1 and the unsigned arithmetic never wraps.
    always_comb begin
        next_x     = ball_x;
        next_dir_x = dir_x;
        flip_x     = 1'b0;
        if (dir_x) begin
            if (ball_x >= X_LAST) begin
                next_dir_x = 1'b0;
                flip_x     = 1'b1;
                next_x     = ball_x - 9'd1;
            end else begin
                next_x     = ball_x + 9'd1;
            end
        end else begin
            if (ball_x == 9'd0) begin
                next_dir_x = 1'b1;
                flip_x     = 1'b1;
                next_x     = ball_x + 9'd1;
            end else begin
                next_x     = ball_x - 9'd1;
            end
        end
    end

    // Next y position and direction, same bounce rule as x.
    always_comb begin
        next_y     = ball_y;
        next_dir_y = dir_y;
        flip_y     = 1'b0;
        if (dir_y) begin
            if (ball_y >= Y_LAST) begin
                next_dir_y = 1'b0;
                flip_y     = 1'b1;
                next_y     = ball_y - 8'd1;
            end else begin
                next_y     = ball_y + 8'd1;
            end
        end else begin
            if (ball_y == 8'd0) begin
                next_dir_y = 1'b1;
                flip_y     = 1'b1;
                next_y     = ball_y + 8'd1;
            end else begin
                next_y     = ball_y - 8'd1;
            end
        end
    end

`ifndef BALL_ERASE_EN
    // Without the erase pass every drawer access is a draw.
    assign color = 3'b111;
`endif

    // Frame sequencer. All outputs are registered together with the state so
    // drawer_start, color and the position only ever change on the edge that
    // enters or leaves a handshake state, keeping them stable while the
    // drawer is busy. The position itself changes only on the MOVE edge,
    // which always lies between two handshakes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ball_x       <= X_RESET;
            ball_y       <= Y_RESET;
            dir_x        <= 1'b1;
            dir_y        <= 1'b1;
            wait_cnt     <= '0;
            drawer_start <= 1'b0;
            busy         <= 1'b0;
            bounce       <= 1'b0;
`ifdef BALL_ERASE_EN
            color        <= 3'b000;
`endif
        end else begin
            bounce <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        busy <= 1'b1;
`ifdef BALL_ERASE_EN
                        state        <= S_ERASE;
                        drawer_start <= 1'b1;
                        color        <= 3'b000;
`else
                        state        <= S_MOVE;
`endif
                    end
                end

`ifdef BALL_ERASE_EN
                S_ERASE: begin
                    if (drawer_done) begin
                        state        <= S_ERASE_REL;
                        drawer_start <= 1'b0;
                    end
                end

                // One cycle with start low lets the drawer return to IDLE.
                S_ERASE_REL: begin
                    state <= S_MOVE;
                end
`endif

                S_MOVE: begin
                    ball_x       <= next_x;
                    ball_y       <= next_y;
                    dir_x        <= next_dir_x;
                    dir_y        <= next_dir_y;
                    // A corner hit flips both axes but yields one pulse.
                    bounce       <= flip_x | flip_y;
                    state        <= S_DRAW;
                    drawer_start <= 1'b1;
`ifdef BALL_ERASE_EN
                    color        <= 3'b111;
`endif
                end

                // enable is deliberately ignored here: the handshake and its
                // release cycle always complete so the drawer is never left
                // in its DONE state.
                S_DRAW: begin
                    if (drawer_done) begin
                        state        <= S_DRAW_REL;
                        drawer_start <= 1'b0;
                    end
                end

                S_DRAW_REL: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
`ifdef BALL_ERASE_EN
                        state        <= S_ERASE;
                        drawer_start <= 1'b1;
                        color        <= 3'b000;
`else
                        state        <= S_MOVE;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    drawer_start <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Sequences the 2x2 ball drawer once per frame period: erase the ball at its old position, step it by one pixel, then redraw it at the new position.
- Bounces the ball off the screen edges.
- Sits between game-level enable logic and the ball drawer. Drives the drawer's start/x/y and supplies pixel colour to the bitmap write path.

Parameters:
X_MAX, 319, rightmost screen column; ball legal x range 0..X_MAX-1
Y_MAX, 239, bottom screen row; ball legal y range 0..Y_MAX-1
X_INIT, 160, ball x after reset
Y_INIT, 120, ball y after reset
WAIT_CYCLES, 1000000, idle clocks between frames (step rate)

Ports:
clk  input  1  system clock
reset_n  input  1  reset
enable  input  1  run ball motion while high
drawer_start  output  1  start request to ball drawer
drawer_done  input  1  one-cycle done pulse from ball drawer
ball_x  output  9  top-left x sent to drawer
ball_y  output  8  top-left y sent to drawer
color  output  3  pixel colour for bitmap: 3'b000 erase, 3'b111 draw
busy  output  1  high in any state other than IDLE
bounce  output  1  one-cycle pulse when direction flips

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset_n low, any time, including mid-draw):
  - state IDLE; ball_x=X_INIT, ball_y=Y_INIT; dir_x=+1, dir_y=+1; wait counter 0.
  - drawer_start=0, color=0, busy=0, bounce=0.
  - The drawer has its own reset; the controller makes no attempt to finish a handshake.
- States: IDLE, ERASE, ERASE_REL, MOVE, DRAW, DRAW_REL, WAIT.
- IDLE: when enable=1, go to ERASE on the next edge.
- ERASE:
  - drawer_start=1, color=000, ball_x/ball_y = current position.
  - Hold until drawer_done=1 is sampled, then go to ERASE_REL.
- ERASE_REL: drawer_start=0 for exactly 1 cycle so the drawer returns to IDLE. Then go to MOVE.
- MOVE (1 cycle): update the position, then go to DRAW.
  - x: if dir_x=+1 and x==X_MAX-1, set dir_x=-1 and x=x-1. If dir_x=-1 and x==0, set dir_x=+1 and x=x+1. Otherwise x=x+dir_x.
  - y: same rule, using Y_MAX-1 and 0.
  - bounce=1 on the cycle after MOVE if either axis flipped. A corner hit flips both axes and gives a single pulse.
  - Arithmetic is unsigned at the port width and never wraps.
- DRAW:
  - drawer_start=1, color=111, new position.
  - Hold until drawer_done, then go to DRAW_REL.
- DRAW_REL: drawer_start=0 for 1 cycle. Clear the counter, then go to WAIT.
- WAIT:
  - Count WAIT_CYCLES clocks, then go to ERASE if enable=1, otherwise IDLE.
  - If enable drops during WAIT, go to IDLE immediately.
  - If enable drops during ERASE/DRAW, complete that handshake and its REL cycle first. The drawer is never left in its DONE state.
- color and ball_x/ball_y are stable the whole time drawer_start is high.
- drawer_done arriving outside ERASE/DRAW is ignored.
- A pulse in the same cycle start rises is accepted: the transition happens on the next edge.
- Frame latency = erase drawer time + draw drawer time + 3 + WAIT_CYCLES.

Optional Feature:
- Macro: BALL_ERASE_EN.
- Defined: behaviour as above.
- Undefined:
  - The ERASE and ERASE_REL states are not compiled. IDLE and WAIT go directly to MOVE, so the ball leaves a trail.
  - color is constant 3'b111.
  - Frame latency = draw drawer time + 2 + WAIT_CYCLES.

Test Plan:
1. Reset with reset_n=0, enable=0 -> ball_x=160, ball_y=120, drawer_start=0, busy=0, color=000. The state holds IDLE for 20 cycles.
2. WAIT_CYCLES=4, enable=1, drawer model pulses done 4 cycles after start -> erase at (160,120) with color=000, then draw at (161,121) with color=111. drawer_start is low exactly 1 cycle between them. The next erase starts after 4 WAIT cycles.
3. X_INIT=317, Y_INIT=100 -> frame 1 draws at x=318, no bounce. Frame 2 draws at x=317, dir_x=-1, bounce pulses once.
4. X_INIT=318, Y_INIT=238 -> the next draw is at (317,237) with exactly one bounce pulse. The following frame is at (316,236).
5. Drop enable while in DRAW with done pending -> drawer_done is still accepted, DRAW_REL follows, and the state goes to IDLE with busy=0. Re-asserting enable resumes from the last position.
6. Assert reset_n=0 asynchronously mid-ERASE -> all outputs reach their reset values before the next clk edge. With BALL_ERASE_EN undefined, check that no color=000 cycle ever occurs.
